// File: rtl/button_debouncer_pkg.sv
// Shared constants for the push-button conditioning stage.
// Board clock rate and the default debounce/hold cycle counts.
package button_debouncer_pkg;

  localparam int CLK_HZ = 100_000_000;

  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED  = 1'b0;

  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int HOLD_1S       = CLK_HZ;

  // Counter width able to hold 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bus between the raw inputs, the debouncer and its consumers.
// master drives the raw buttons, slave is the conditioning stage.
interface button_debouncer_if #(
  parameter int NUM_BTN = 4
);

  logic [NUM_BTN-1:0] SW;
  logic [NUM_BTN-1:0] SW_Clean;
  logic [NUM_BTN-1:0] Pressed;
  logic [NUM_BTN-1:0] PressPulse;
  logic [NUM_BTN-1:0] ReleasePulse;
  logic [NUM_BTN-1:0] HoldPulse;

  modport master (
    output SW,
    input  SW_Clean,
    input  Pressed,
    input  PressPulse,
    input  ReleasePulse,
    input  HoldPulse
  );

  modport slave (
    input  SW,
    output SW_Clean,
    output Pressed,
    output PressPulse,
    output ReleasePulse,
    output HoldPulse
  );

endinterface

// File: rtl/button_debouncer_debounce_channel.sv
// One button: 2-flop synchronizer, debounce counter, hold counter
// and registered press/release/hold event pulses.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int HOLD_CYCLES     = HOLD_1S
) (
  input  logic Clk,
  input  logic Rst,
  input  logic sw,
  output logic sw_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_CYCLES - 2);

  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          hold_fired;
  logic          mismatch;
  logic          accept;
  logic          hold_hit;

  assign mismatch = (s2 != sw_clean);
  assign accept   = mismatch && (db_cnt == DB_LAST);
  assign hold_hit = (hold_cnt == HOLD_PRE) && !hold_fired;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1 <= BTN_RELEASED;
      s2 <= BTN_RELEASED;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Any sample agreeing with the accepted level drops all progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      db_cnt        <= '0;
      sw_clean      <= BTN_RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= accept && (s2 == BTN_PRESSED);
      release_pulse <= accept && (s2 == BTN_RELEASED);
      if (!mismatch || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      if (accept) begin
        sw_clean <= s2;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || sw_clean == BTN_RELEASED) begin
      hold_cnt   <= '0;
      hold_fired <= 1'b0;
      hold_pulse <= 1'b0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt   <= hold_cnt + HW'(1);
      hold_pulse <= hold_hit;
      if (hold_hit) begin
        hold_fired <= 1'b1;
      end
    end else begin
      hold_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Conditions NUM_BTN raw active-low buttons into a clean level bus
// plus per-button press, release and long-hold event pulses.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int HOLD_CYCLES     = HOLD_1S
) (
  input  logic        Clk,
  input  logic        Rst,
  button_debouncer_if.slave bus
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .Clk           (Clk),
      .Rst           (Rst),
      .sw            (bus.SW[g]),
      .sw_clean      (bus.SW_Clean[g]),
      .press_pulse   (bus.PressPulse[g]),
      .release_pulse (bus.ReleasePulse[g]),
      .hold_pulse    (bus.HoldPulse[g])
    );
  end

  assign bus.Pressed = ~bus.SW_Clean;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Upstream conditioning stage for the 4-button push-button expansion module on the Spartan-6 board. It takes raw active-low mechanical button inputs and applies a two-flop synchronizer and a per-button debounce counter. Outputs are a clean active-low bus that drops directly into the LED-pattern stage, plus one-cycle press, release and long-hold event pulses for downstream logic.

Parameters:
NUM_BTN, 4, number of independent button channels
DEBOUNCE_CYCLES, 1000000, consecutive stable Clk cycles required to accept a level change (10 ms at 100 MHz); must be >= 2
HOLD_CYCLES, 100000000, Clk cycles a button must stay debounced-pressed before HoldPulse fires (1 s at 100 MHz); must be >= 2

Ports:
Clk  input  1  system clock, 100 MHz
Rst  input  1  synchronous, active-high reset
SW  input  NUM_BTN  raw buttons, active-low (0 = pressed), asynchronous to Clk
SW_Clean  output  NUM_BTN  debounced buttons, active-low, registered
Pressed  output  NUM_BTN  debounced level, active-high (bitwise inverse of SW_Clean)
PressPulse  output  NUM_BTN  one-cycle pulse when a channel becomes debounced-pressed
ReleasePulse  output  NUM_BTN  one-cycle pulse when a channel becomes debounced-released
HoldPulse  output  NUM_BTN  one-cycle pulse after HOLD_CYCLES of continuous debounced press

Behaviour:
- One clock domain: Clk. Rst is synchronous and active-high; all state updates on posedge Clk.
- Reset values:
  - Synchronizer flops = 1 (released).
  - SW_Clean = all 1s; Pressed = 0.
  - PressPulse, ReleasePulse, HoldPulse = 0.
  - All counters = 0; hold-fired flags = 0.
- Synchronizer: two flops per bit, SW -> s1 -> s2. The debounce logic sees only s2.
- Debounce counter, per channel, width clog2(DEBOUNCE_CYCLES):
  - If s2 == SW_Clean[i]: counter <= 0.
  - Else, if counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - Else (counter == DEBOUNCE_CYCLES-1 with mismatch still present): SW_Clean[i] <= s2, counter <= 0.
  - Result: a level is accepted after exactly DEBOUNCE_CYCLES consecutive mismatching s2 samples.
  - Any single-cycle agreement (a glitch) clears the counter. No partial credit is kept.
- Latency: a clean edge on SW reaches SW_Clean after 2 + DEBOUNCE_CYCLES Clk cycles.
- Event pulses:
  - PressPulse[i] is high for exactly the one cycle in which SW_Clean[i] is registered 1->0.
  - ReleasePulse[i] is the same for 0->1.
  - Pulses are registered and coincide with the first cycle of the new SW_Clean value.
- Hold counter, per channel, width clog2(HOLD_CYCLES):
  - Cleared while SW_Clean[i] == 1.
  - While pressed, increments each cycle.
  - When it reaches HOLD_CYCLES-1, HoldPulse[i] asserts for one cycle and the hold-fired flag sets. The counter then saturates.
  - The flag clears on release. At most one HoldPulse per press.
- Channels are fully independent. Simultaneous changes on several buttons produce simultaneous pulses. There is no priority encoding; that belongs to the downstream stage.
- Reset mid-count (debounce or hold) abandons the count. The output returns to the released state with no Release/Hold pulse emitted.
- Reset asserted while a button is physically held: after Rst deasserts, a fresh PressPulse occurs after 2 + DEBOUNCE_CYCLES cycles.

Decomposition:
- Shared package/header holds:
  - constants CLK_HZ = 100_000_000, BTN_RELEASED = 1'b1, BTN_PRESSED = 1'b0;
  - default cycle counts DEBOUNCE_10MS and HOLD_1S.
- One natural sub-module: debounce_channel (single bit: synchronizer, debounce counter, hold counter, three pulses). button_debouncer instantiates it NUM_BTN times in a generate loop.

Test Plan:
(Test parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.)
1. Reset, SW=4'hF held -> SW_Clean=4'hF, Pressed=0, no pulses for 50 cycles.
2. SW[0] 1->0 cleanly at cycle t -> SW_Clean[0]=0 and PressPulse[0]=1 for exactly one cycle at t+6. Other bits stay unchanged.
3. SW[1] bounces 0,1,0,1,0 every cycle, then holds 0 -> no PressPulse during the bounce. A single PressPulse[1] fires 6 cycles after the last edge.
4. SW[2] held low for 30 cycles -> one PressPulse[2], then exactly one HoldPulse[2] 9 cycles later. Release gives ReleasePulse[2] 6 cycles after the SW edge and no second HoldPulse.
5. SW[0] and SW[3] fall on the same cycle -> PressPulse=4'b1001 in a single cycle.
6. Rst pulsed 2 cycles into a debounce count, with SW[1] still low -> no pulse during reset. PressPulse[1] fires 6 cycles after Rst deasserts.
